// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// FSM state encoding, port-count limits and packed-slice indexing.
package regfile_pkg;

  typedef enum logic [0:0] {
    RF_INIT  = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  localparam int unsigned MaxReadPorts  = 4;
  localparam int unsigned MaxWritePorts = 3;

  // Low bit of slice idx in a vector of width-bit fields.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-register scoreboard: reserve sets, accepted writes clear, clear_i flushes.
// busy_o reports pending per read port, masked by a same-cycle write to that register.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 5,
  parameter int unsigned NUM_REGISTERS   = 32,
  parameter int unsigned NUM_READ_PORTS  = 2,
  parameter int unsigned NUM_WRITE_PORTS = 2
) (
  input  logic                                  clk_i,
  input  logic                                  rst_n_i,
  input  logic                                  active_i,
  input  logic                                  flush_i,
  input  logic                                  reserve_en_i,
  input  logic [ADDR_WIDTH-1:0]                 reserve_addr_i,
  input  logic [NUM_WRITE_PORTS-1:0]            wr_acc_i,
  input  logic [NUM_WRITE_PORTS*ADDR_WIDTH-1:0] write_addr_i,
  input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0]  read_addr_i,
  output logic [NUM_READ_PORTS-1:0]             busy_o
);

  logic [NUM_REGISTERS-1:0] pending_q, pending_d;

  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return (a != '0) && (32'(a) < NUM_REGISTERS);
  endfunction

  always_comb begin
    pending_d = pending_q;
    if (active_i) begin
      for (int k = 0; k < NUM_WRITE_PORTS; k++) begin
        if (wr_acc_i[k]) begin
          pending_d[write_addr_i[slice_lo(k, ADDR_WIDTH) +: ADDR_WIDTH]] = 1'b0;
        end
      end
      // Reserve applied after the write clears so it wins on a collision.
      if (reserve_en_i && addr_ok(reserve_addr_i)) begin
        pending_d[reserve_addr_i] = 1'b1;
      end
      if (flush_i) begin
        pending_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  always_comb begin
    logic [ADDR_WIDTH-1:0] ra;
    logic                  hit;
    busy_o = '0;
    ra     = '0;
    hit    = 1'b0;
    for (int r = 0; r < NUM_READ_PORTS; r++) begin
      ra  = read_addr_i[slice_lo(r, ADDR_WIDTH) +: ADDR_WIDTH];
      hit = 1'b0;
      for (int k = 0; k < NUM_WRITE_PORTS; k++) begin
        if (wr_acc_i[k] && (write_addr_i[slice_lo(k, ADDR_WIDTH) +: ADDR_WIDTH] == ra)) begin
          hit = 1'b1;
        end
      end
      if (active_i && addr_ok(ra)) begin
        busy_o[r] = pending_q[ra] & ~hit;
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-to-read bypass, hardwired r0 and a sequential clear engine.
// Define REGFILE_SCOREBOARD_EN to add the pending-register scoreboard and its ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned ADDR_WIDTH      = 5,
  parameter int unsigned NUM_REGISTERS   = 32,
  parameter int unsigned NUM_READ_PORTS  = 2,
  parameter int unsigned NUM_WRITE_PORTS = 2
) (
  input  logic                                  clk_i,
  input  logic                                  rst_n_i,
  input  logic                                  clear_i,
  output logic                                  ready_o,
  input  logic [NUM_WRITE_PORTS-1:0]            write_en_i,
  input  logic [NUM_WRITE_PORTS*ADDR_WIDTH-1:0] write_addr_i,
  input  logic [NUM_WRITE_PORTS*DATA_WIDTH-1:0] write_data_i,
`ifdef REGFILE_SCOREBOARD_EN
  input  logic                                  reserve_en_i,
  input  logic [ADDR_WIDTH-1:0]                 reserve_addr_i,
  output logic [NUM_READ_PORTS-1:0]             busy_o,
`endif
  input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0]  read_addr_i,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0]  read_data_o
);

  localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(NUM_REGISTERS - 1);

  rf_state_e             state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  ready_q;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGISTERS];

  logic [NUM_WRITE_PORTS-1:0] wr_acc;
  logic [ADDR_WIDTH-1:0]      wr_addr [NUM_WRITE_PORTS];
  logic [DATA_WIDTH-1:0]      wr_data [NUM_WRITE_PORTS];
  logic                       active;

  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return (a != '0) && (32'(a) < NUM_REGISTERS);
  endfunction

  assign active  = (state_q == RF_READY);
  assign ready_o = ready_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= RF_INIT;
      cnt_q   <= ADDR_WIDTH'(1);
      ready_q <= 1'b0;
    end else begin
      unique case (state_q)
        RF_INIT: begin
          if (cnt_q == LastIdx) begin
            state_q <= RF_READY;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + ADDR_WIDTH'(1);
          end
        end
        RF_READY: begin
          if (clear_i) begin
            state_q <= RF_INIT;
            cnt_q   <= ADDR_WIDTH'(1);
            ready_q <= 1'b0;
          end
        end
        default: begin
          state_q <= RF_INIT;
          cnt_q   <= ADDR_WIDTH'(1);
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_WRITE_PORTS; k++) begin
      wr_addr[k] = write_addr_i[slice_lo(k, ADDR_WIDTH) +: ADDR_WIDTH];
      wr_data[k] = write_data_i[slice_lo(k, DATA_WIDTH) +: DATA_WIDTH];
      wr_acc[k]  = active && write_en_i[k] && addr_ok(wr_addr[k]);
    end
  end

  // Storage is deliberately unreset; the INIT sweep zeroes it. Later ports override earlier ones.
  always_ff @(posedge clk_i) begin
    if (state_q == RF_INIT) begin
      regs_q[cnt_q] <= '0;
    end else begin
      for (int k = 0; k < NUM_WRITE_PORTS; k++) begin
        if (wr_acc[k]) begin
          regs_q[wr_addr[k]] <= wr_data[k];
        end
      end
    end
  end

  always_comb begin
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] rd;
    read_data_o = '0;
    ra          = '0;
    rd          = '0;
    for (int r = 0; r < NUM_READ_PORTS; r++) begin
      ra = read_addr_i[slice_lo(r, ADDR_WIDTH) +: ADDR_WIDTH];
      rd = '0;
      if (active && addr_ok(ra)) begin
        rd = regs_q[ra];
        for (int k = 0; k < NUM_WRITE_PORTS; k++) begin
          if (wr_acc[k] && (wr_addr[k] == ra)) begin
            rd = wr_data[k];
          end
        end
      end
      read_data_o[slice_lo(r, DATA_WIDTH) +: DATA_WIDTH] = rd;
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  regfile_scoreboard #(
    .ADDR_WIDTH      (ADDR_WIDTH),
    .NUM_REGISTERS   (NUM_REGISTERS),
    .NUM_READ_PORTS  (NUM_READ_PORTS),
    .NUM_WRITE_PORTS (NUM_WRITE_PORTS)
  ) u_scoreboard (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .active_i       (active),
    .flush_i        (clear_i),
    .reserve_en_i   (reserve_en_i),
    .reserve_addr_i (reserve_addr_i),
    .wr_acc_i       (wr_acc),
    .write_addr_i   (write_addr_i),
    .read_addr_i    (read_addr_i),
    .busy_o         (busy_o)
  );
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp at default parameters; scoreboard checks run when
// REGFILE_SCOREBOARD_EN is defined.
module tb_regfile_mp;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        ready;
  logic [1:0]  we;
  logic [9:0]  waddr;
  logic [31:0] wdata;
  logic [9:0]  raddr;
  logic [31:0] rdata;
`ifdef REGFILE_SCOREBOARD_EN
  logic        res_en;
  logic [4:0]  res_addr;
  logic [1:0]  busy;
`endif

  int checks;
  int failures;

  regfile_mp dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .clear_i        (clear),
    .ready_o        (ready),
    .write_en_i     (we),
    .write_addr_i   (waddr),
    .write_data_i   (wdata),
`ifdef REGFILE_SCOREBOARD_EN
    .reserve_en_i   (res_en),
    .reserve_addr_i (res_addr),
    .busy_o         (busy),
`endif
    .read_addr_i    (raddr),
    .read_data_o    (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [15:0] wd0;
    logic [4:0]  wa1;
    logic [15:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [15:0] e0;
    logic [15:0] e1;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] w, input logic [4:0] a0, input logic [15:0] d0,
                       input logic [4:0] a1, input logic [15:0] d1,
                       input logic [4:0] r0, input logic [4:0] r1, input logic c);
    we    = w;
    waddr = {a1, a0};
    wdata = {d1, d0};
    raddr = {r1, r0};
    clear = c;
  endtask

  task automatic idle(input logic [4:0] r0, input logic [4:0] r1);
    drive(2'b00, 5'd0, 16'h0, 5'd0, 16'h0, r0, r1, 1'b0);
  endtask

  // Counts edges from the current point; ready_o must be low until exactly 31 edges.
  task automatic sweep(input string nm);
    for (int e = 1; e <= 31; e++) begin
      tick();
      if (e == 30 || e == 31) begin
        chk(nm, {15'b0, ready}, {15'b0, (e == 31)});
      end else if (ready !== 1'b0) begin
        chk(nm, {15'b0, ready}, 16'h0);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    idle(5'd5, 5'd0);
`ifdef REGFILE_SCOREBOARD_EN
    res_en   = 1'b0;
    res_addr = 5'd0;
`endif

    vecs[0]  = '{2'b00, 5'd0,  16'h0000, 5'd0,  16'h0000, 5'd5,  5'd0,  16'h0000, 16'h0000};
    vecs[1]  = '{2'b01, 5'd3,  16'hBEEF, 5'd0,  16'h0000, 5'd3,  5'd5,  16'hBEEF, 16'h0000};
    vecs[2]  = '{2'b00, 5'd0,  16'h0000, 5'd0,  16'h0000, 5'd3,  5'd3,  16'hBEEF, 16'hBEEF};
    vecs[3]  = '{2'b11, 5'd7,  16'h1111, 5'd7,  16'h2222, 5'd7,  5'd3,  16'h2222, 16'hBEEF};
    vecs[4]  = '{2'b00, 5'd0,  16'h0000, 5'd0,  16'h0000, 5'd7,  5'd0,  16'h2222, 16'h0000};
    vecs[5]  = '{2'b01, 5'd0,  16'hFFFF, 5'd0,  16'h0000, 5'd0,  5'd0,  16'h0000, 16'h0000};
    vecs[6]  = '{2'b00, 5'd0,  16'h0000, 5'd0,  16'h0000, 5'd0,  5'd7,  16'h0000, 16'h2222};
    vecs[7]  = '{2'b11, 5'd10, 16'h1234, 5'd11, 16'h5678, 5'd10, 5'd11, 16'h1234, 16'h5678};
    vecs[8]  = '{2'b10, 5'd0,  16'h0000, 5'd3,  16'h0CAB, 5'd3,  5'd10, 16'h0CAB, 16'h1234};
    vecs[9]  = '{2'b00, 5'd0,  16'h0000, 5'd0,  16'h0000, 5'd3,  5'd11, 16'h0CAB, 16'h5678};
    vecs[10] = '{2'b11, 5'd12, 16'hAAAA, 5'd0,  16'hFFFF, 5'd12, 5'd0,  16'hAAAA, 16'h0000};
    vecs[11] = '{2'b01, 5'd31, 16'h7777, 5'd0,  16'h0000, 5'd31, 5'd31, 16'h7777, 16'h7777};
    vecs[12] = '{2'b00, 5'd0,  16'h0000, 5'd0,  16'h0000, 5'd31, 5'd12, 16'h7777, 16'hAAAA};
    vecs[13] = '{2'b00, 5'd5,  16'hDEAD, 5'd5,  16'hBEEF, 5'd5,  5'd3,  16'h0000, 16'h0CAB};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", {15'b0, ready}, 16'h0);
    chk("reset_rd0", rdata[15:0], 16'h0);
    chk("reset_rd1", rdata[31:16], 16'h0);
`ifdef REGFILE_SCOREBOARD_EN
    chk("reset_busy", {14'b0, busy}, 16'h0);
`endif
    rst_n = 1'b1;
    sweep("init_ready");
    #3;
    chk("init_r5", rdata[15:0], 16'h0000);

    // Table-driven single-cycle vectors, each checked before its edge
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].we, vecs[i].wa0, vecs[i].wd0, vecs[i].wa1, vecs[i].wd1,
            vecs[i].ra0, vecs[i].ra1, 1'b0);
      #3;
      chk($sformatf("vec%0d_p0", i), rdata[15:0], vecs[i].e0);
      chk($sformatf("vec%0d_p1", i), rdata[31:16], vecs[i].e1);
      tick();
    end

`ifdef REGFILE_SCOREBOARD_EN
    idle(5'd4, 5'd0);
    res_en   = 1'b1;
    res_addr = 5'd4;
    #3;
    chk("sb_reserve_same", {15'b0, busy[0]}, 16'h0);
    tick();
    res_en = 1'b0;
    #3;
    chk("sb_reserve_next", {15'b0, busy[0]}, 16'h1);
    drive(2'b01, 5'd4, 16'h0042, 5'd0, 16'h0, 5'd4, 5'd0, 1'b0);
    #3;
    chk("sb_write_busy", {15'b0, busy[0]}, 16'h0);
    chk("sb_write_rd", rdata[15:0], 16'h0042);
    tick();
    idle(5'd4, 5'd0);
    #3;
    chk("sb_after_write_busy", {15'b0, busy[0]}, 16'h0);
    chk("sb_after_write_rd", rdata[15:0], 16'h0042);
    drive(2'b01, 5'd4, 16'h0099, 5'd0, 16'h0, 5'd4, 5'd0, 1'b0);
    res_en   = 1'b1;
    res_addr = 5'd4;
    #3;
    chk("sb_collide_same", {15'b0, busy[0]}, 16'h0);
    tick();
    res_addr = 5'd0;
    idle(5'd4, 5'd0);
    #3;
    chk("sb_collide_next", {15'b0, busy[0]}, 16'h1);
    chk("sb_collide_rd", rdata[15:0], 16'h0099);
    tick();
    res_en = 1'b0;
    #3;
    chk("sb_r0_ignored", {15'b0, busy[1]}, 16'h0);
`endif

    // Write r9 in the clear cycle; write is accepted then wiped by the sweep
    drive(2'b01, 5'd9, 16'hAAAA, 5'd0, 16'h0, 5'd9, 5'd3, 1'b1);
    #3;
    chk("clr_bypass", rdata[15:0], 16'hAAAA);
    tick();
    idle(5'd9, 5'd3);
    chk("clr_ready_drop", {15'b0, ready}, 16'h0);
    for (int e = 1; e <= 31; e++) begin
      if (e == 10) begin
        clear = 1'b1;
      end else if (e == 20) begin
        drive(2'b01, 5'd9, 16'h5555, 5'd0, 16'h0, 5'd9, 5'd3, 1'b0);
        #3;
        chk("init_rd_zero", rdata[15:0], 16'h0000);
`ifdef REGFILE_SCOREBOARD_EN
        chk("init_busy_zero", {14'b0, busy}, 16'h0);
`endif
      end else begin
        idle(5'd9, 5'd3);
      end
      tick();
      if (e == 30 || e == 31) begin
        chk("clr_ready", {15'b0, ready}, {15'b0, (e == 31)});
      end else if (ready !== 1'b0) begin
        chk("clr_ready_low", {15'b0, ready}, 16'h0);
      end
    end
    idle(5'd9, 5'd3);
    #3;
    chk("clr_r9", rdata[15:0], 16'h0000);
    chk("clr_r3", rdata[31:16], 16'h0000);
`ifdef REGFILE_SCOREBOARD_EN
    idle(5'd4, 5'd9);
    #1;
    chk("clr_busy", {15'b0, busy[0]}, 16'h0);
`endif

    // Reset asserted mid-INIT restarts the full sweep
    drive(2'b01, 5'd6, 16'h6666, 5'd0, 16'h0, 5'd6, 5'd0, 1'b1);
    tick();
    idle(5'd6, 5'd0);
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    chk("midinit_rst_ready", {15'b0, ready}, 16'h0);
    tick();
    rst_n = 1'b1;
    sweep("midinit_sweep");

    // Reset asserted in READY drops ready_o immediately
    rst_n = 1'b0;
    #1;
    chk("ready_rst_async", {15'b0, ready}, 16'h0);
    tick();
    rst_n = 1'b1;
    sweep("ready_rst_sweep");
    #3;
    chk("final_r6", rdata[15:0], 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
